// File: rtl/distance_bit_packer.sv
// distance_bit_packer
//   Packs right-aligned variable-length codes (0..IN_W valid bits each) MSB-first into a
//   continuous stream of OUT_W-bit words. A flush request drains all pending full words and
//   then emits the zero-padded partial tail word tagged with out_last and its bit count.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   code_data/len/valid   code input; valid bits are code_data[code_len-1:0]
//   code_ready            code accepted this cycle when code_valid is also high
//   flush, flush_ack      level flush request; ack pulses when the request is taken
//   out_data/bits/last    packed word, its valid bit count, tail marker
//   out_valid, out_ready  output handshake
//   len_err               sticky: a code with code_len > IN_W was accepted (clamped to IN_W)
//
// Configuration
//   BIT_PACKER_STATS_EN   when defined, adds stat_bits (sum of accepted clamped lengths) and
//                         stat_words (output handshakes), both 32-bit wrapping counters.
module distance_bit_packer #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned LEN_W = 6,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  code_data,
    input  logic [LEN_W-1:0] code_len,
    input  logic             code_valid,
    output logic             code_ready,
    input  logic             flush,
    output logic             flush_ack,
    output logic [OUT_W-1:0] out_data,
    output logic [LEN_W-1:0] out_bits,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             len_err
`ifdef BIT_PACKER_STATS_EN
    ,
    output logic [31:0]      stat_bits,
    output logic [31:0]      stat_words
`endif
);

    localparam int unsigned ACC_W  = OUT_W + IN_W;
    localparam int unsigned FILL_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {StRun, StDrain, StTail} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               len_err_q, len_err_d;

    logic               word_full;
    logic               accept;
    logic               emit;
    logic               len_over;
    logic [LEN_W-1:0]   len_c;
    logic [IN_W-1:0]    code_mask;
    logic [ACC_W-1:0]   code_placed;
    logic [FILL_W-1:0]  place_sh;
    logic [OUT_W-1:0]   tail_mask;

    // ---------------------------------------------------------------- datapath decode
    always_comb begin
        len_over = code_len > LEN_W'(IN_W);
        len_c    = len_over ? LEN_W'(IN_W) : code_len;
        if (len_c >= LEN_W'(IN_W)) begin
            code_mask = '1;
        end else begin
            code_mask = (IN_W'(1) << len_c) - IN_W'(1);
        end
        // Left-justify the code just below the bits already held: its MSB lands on
        // acc[ACC_W-1-fill]. Only evaluated with fill < OUT_W, so the shift stays positive.
        place_sh    = FILL_W'(ACC_W) - FILL_W'(len_c) - fill_q;
        code_placed = ACC_W'(code_data & code_mask) << place_sh;
    end

    assign word_full  = fill_q >= FILL_W'(OUT_W);
    assign code_ready = (state_q == StRun) && !word_full;
    assign accept     = code_valid && code_ready;
    assign out_valid  = word_full || (state_q == StTail);
    assign emit       = out_valid && out_ready;
    // A pending code wins over flush unless the packer cannot take it anyway.
    assign flush_ack  = flush && (state_q == StRun) && (word_full || !code_valid);
    assign len_err    = len_err_q;

    // ---------------------------------------------------------------- output word
    always_comb begin
        tail_mask = ~({OUT_W{1'b1}} >> fill_q);
        out_data  = '0;
        out_bits  = '0;
        out_last  = 1'b0;
        if (state_q == StTail) begin
            out_data = acc_q[ACC_W-1 -: OUT_W] & tail_mask;
            out_bits = LEN_W'(fill_q);
            out_last = 1'b1;
        end else if (word_full) begin
            out_data = acc_q[ACC_W-1 -: OUT_W];
            out_bits = LEN_W'(OUT_W);
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        acc_d     = acc_q;
        fill_d    = fill_q;
        state_d   = state_q;
        len_err_d = len_err_q | (accept && len_over);

        // accept and emit never coincide: they need fill < OUT_W and fill >= OUT_W resp.
        if (accept) begin
            acc_d  = acc_q | code_placed;
            fill_d = fill_q + FILL_W'(len_c);
        end
        if (emit) begin
            if (state_q == StTail) begin
                acc_d  = '0;
                fill_d = '0;
            end else begin
                acc_d  = acc_q << OUT_W;
                fill_d = fill_q - FILL_W'(OUT_W);
            end
        end

        unique case (state_q)
            StRun: begin
                if (flush_ack) begin
                    if (word_full) begin
                        state_d = StDrain;
                    end else if (fill_q != '0) begin
                        state_d = StTail;
                    end
                end
            end
            StDrain: begin
                if (!word_full) begin
                    state_d = (fill_q == '0) ? StRun : StTail;
                end
            end
            StTail: begin
                if (emit) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            acc_q     <= '0;
            fill_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            len_err_q <= len_err_d;
        end
    end

`ifdef BIT_PACKER_STATS_EN
    logic [31:0] stat_bits_q, stat_bits_d;
    logic [31:0] stat_words_q, stat_words_d;

    always_comb begin
        stat_bits_d  = stat_bits_q;
        stat_words_d = stat_words_q;
        if (accept) begin
            stat_bits_d = stat_bits_q + 32'(len_c);
        end
        if (emit) begin
            stat_words_d = stat_words_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bits_q  <= '0;
            stat_words_q <= '0;
        end else begin
            stat_bits_q  <= stat_bits_d;
            stat_words_q <= stat_words_d;
        end
    end

    assign stat_bits  = stat_bits_q;
    assign stat_words = stat_words_q;
`endif

endmodule
